// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART definitions: state encoding, baud derivation and
//            frame constants used by the uart_rx_* and uart_tx_* blocks.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS    = 8;
    localparam int STOP_BIT_IDX = 9;

    // Clock cycles per bit cell.
    function automatic int calc_baud_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Mid-bit point of a bit cell.
    function automatic int calc_half(input int baud_cnt);
        return baud_cnt / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ly_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ly_if
// Brief    : Serial line in, received byte stream out. The slave modport is
//            the receiver side; the master side drives the line and consumes
//            the byte strobes.
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_ly_if;

    logic       line_rx;
    logic [7:0] po_data;
    logic       rx_down;
    logic       frame_err;

    modport master (
        output line_rx,
        input  po_data,
        input  rx_down,
        input  frame_err
    );

    modport slave (
        input  line_rx,
        output po_data,
        output rx_down,
        output frame_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Brief    : Two-flop synchroniser for the asynchronous serial pin plus a
//            delayed copy used for falling-edge detection.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic line_rx,
    output logic      sync,
    output logic      fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchroniser chain and edge-detect history; idle-high after reset so
    // reset release on an idle line never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= line_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync = r_sync;
    assign fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ly.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ly
// Brief    : 8N1 UART receiver, LSB first, 3-sample majority vote at mid-bit.
//            Emits po_data with a one-cycle rx_down strobe per good frame and
//            a one-cycle frame_err strobe when the stop bit reads low.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_ly
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input wire logic   clk,
    input wire logic   rst_n,
    uart_rx_ly_if.slave rx_if
);

    localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, BAUD);
    localparam int H        = calc_half(BAUD_CNT);
    localparam int CW       = $clog2(BAUD_CNT);

    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_S2   = CW'(H + 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    logic                 w_sync;
    logic                 w_fall;

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit_idx;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_po_data;
    logic                 r_rx_down;
    logic                 r_frame_err;

    logic                 w_cnt_last;
    logic                 w_decide;
    logic                 w_maj;
    logic                 w_shift_en;
    logic                 w_load;
    logic                 w_ferr;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_rx (rx_if.line_rx),
        .sync    (w_sync),
        .fall    (w_fall)
    );

    // The third sample is taken live at H+1, so every decision is registered
    // on the edge closing that cycle and its result is visible at H+2.
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_decide   = (r_cnt == CNT_S2);
    assign w_maj      = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_sync) |
                        (r_samp[1] & w_sync);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle actions.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_decide && w_maj) begin
                    w_state_nxt = IDLE;
                end else if (w_cnt_last) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_decide) begin
                    w_shift_en = 1'b1;
                end
                if (w_cnt_last && (r_bit_idx == IDX_LAST)) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_decide) begin
                    w_state_nxt = IDLE;
                    w_load      = w_maj;
                    w_ferr      = ~w_maj;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Baud counter: held at 0 in IDLE, cleared when entering IDLE, wraps per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == IDLE) || (w_state_nxt == IDLE) || w_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Data bit index, restarted during the start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx <= '0;
        end else if (r_state == START) begin
            r_bit_idx <= '0;
        end else if ((r_state == DATA) && w_cnt_last) begin
            r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    // First two mid-bit samples; the third is the live synchronised value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp <= '0;
        end else begin
            if (r_cnt == CNT_S0) begin
                r_samp[0] <= w_sync;
            end
            if (r_cnt == CNT_S1) begin
                r_samp[1] <= w_sync;
            end
        end
    end

    // Right-shifting assembly register: first (LSB) bit ends up in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        end
    end

    // Output byte and strobes; po_data only changes on a good stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_po_data   <= '0;
            r_rx_down   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_down   <= w_load;
            r_frame_err <= w_ferr;
            if (w_load) begin
                r_po_data <= r_shift;
            end
        end
    end

    // Simulation-only guard: the sample window needs at least 8 clocks per bit.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (BAUD_CNT >= 8) else $error("uart_rx_ly: BAUD_CNT=%0d below 8 is unsupported", BAUD_CNT);
        end
    end

    assign rx_if.po_data   = r_po_data;
    assign rx_if.rx_down   = r_rx_down;
    assign rx_if.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ly.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ly
// Brief    : Directed self-checking bench for uart_rx_ly at 16 clk per bit.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_ly;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 62_500;
    // Line fall to strobe: 3 clk to t0, then 9*16 + 8 + 2.
    localparam int LAT      = 3 + 154;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_ly_if rx_if ();

    uart_rx_ly #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (rx_if)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         rx_cyc[$];
    logic [7:0] rx_val[$];
    int         fe_cyc[$];
    int         overlap_n = 0;
    int         long_n    = 0;
    logic       prev_rx   = 1'b0;
    logic       prev_fe   = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_if.rx_down) begin
            rx_cyc.push_back(cyc);
            rx_val.push_back(rx_if.po_data);
        end
        if (rx_if.frame_err) fe_cyc.push_back(cyc);
        if (rx_if.rx_down && rx_if.frame_err) overlap_n <= overlap_n + 1;
        if ((rx_if.rx_down && prev_rx) || (rx_if.frame_err && prev_fe)) long_n <= long_n + 1;
        prev_rx <= rx_if.rx_down;
        prev_fe <= rx_if.frame_err;
    end

    task automatic clear_log();
        rx_cyc.delete();
        rx_val.delete();
        fe_cyc.delete();
    endtask

    task automatic idle(input int n);
        rx_if.line_rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    // One 16-clk bit cell; optional inverted 1-clk glitch at offset goff.
    task automatic drive_cell(input logic b, input int goff, output int t_drv);
        @(posedge clk);
        #1;
        rx_if.line_rx = b;
        t_drv = cyc;
        if (goff < 0) begin
            repeat (15) @(posedge clk);
        end else begin
            repeat (goff) @(posedge clk);
            #1 rx_if.line_rx = ~b;
            @(posedge clk);
            #1 rx_if.line_rx = b;
            repeat (14 - goff) @(posedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gl_cell,
                             output int t_fall);
        int   t;
        logic v;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : ((i == 9) ? stop : b[i-1]);
            drive_cell(v, (i == gl_cell) ? 9 : -1, t);
            if (i == 0) t_fall = t;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_if.line_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 3;
        if (rx_if.po_data !== 8'h00) begin bad++; $display("FAIL reset_po_data got=%h want=00", rx_if.po_data); end
        if (rx_if.rx_down !== 1'b0) begin bad++; $display("FAIL reset_rx_down got=%b want=0", rx_if.rx_down); end
        if (rx_if.frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", rx_if.frame_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int tf;
        idle(40);
        clear_log();
        send_byte(8'h55, 1'b1, -1, tf);
        idle(20);
        total += 5;
        if (rx_cyc.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", rx_cyc.size()); end
        if (rx_cyc.size() < 1 || rx_cyc[0] != tf + LAT) begin bad++; $display("FAIL single_latency got=%0d want=%0d", (rx_cyc.size() > 0) ? rx_cyc[0] - tf : -1, LAT); end
        if (rx_val.size() < 1 || rx_val[0] !== 8'h55) begin bad++; $display("FAIL single_strobe_data got=%h want=55", (rx_val.size() > 0) ? rx_val[0] : 8'hxx); end
        if (rx_if.po_data !== 8'h55) begin bad++; $display("FAIL single_po_data got=%h want=55", rx_if.po_data); end
        if (fe_cyc.size() != 0) begin bad++; $display("FAIL single_frame_err got=%0d want=0", fe_cyc.size()); end
    endtask

    task automatic test_back_to_back();
        int ta, tb;
        idle(40);
        clear_log();
        send_byte(8'hA3, 1'b1, -1, ta);
        send_byte(8'h0F, 1'b1, -1, tb);
        idle(20);
        total += 5;
        if (rx_cyc.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", rx_cyc.size()); end
        if (rx_cyc.size() < 2 || rx_cyc[1] - rx_cyc[0] != 160) begin bad++; $display("FAIL b2b_spacing got=%0d want=160", (rx_cyc.size() > 1) ? rx_cyc[1] - rx_cyc[0] : -1); end
        if (rx_val.size() < 1 || rx_val[0] !== 8'hA3) begin bad++; $display("FAIL b2b_first got=%h want=a3", (rx_val.size() > 0) ? rx_val[0] : 8'hxx); end
        if (rx_val.size() < 2 || rx_val[1] !== 8'h0F) begin bad++; $display("FAIL b2b_second got=%h want=0f", (rx_val.size() > 1) ? rx_val[1] : 8'hxx); end
        if (rx_if.po_data !== 8'h0F) begin bad++; $display("FAIL b2b_po_data got=%h want=0f", rx_if.po_data); end
    endtask

    task automatic test_false_start();
        int tf;
        idle(40);
        clear_log();
        @(posedge clk);
        #1 rx_if.line_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx_if.line_rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        total += 1;
        if (dut.r_state !== IDLE) begin bad++; $display("FAIL false_start_idle got=%0d want=%0d", dut.r_state, IDLE); end
        idle(30);
        total += 2;
        if (rx_cyc.size() != 0) begin bad++; $display("FAIL false_start_rx got=%0d want=0", rx_cyc.size()); end
        if (fe_cyc.size() != 0) begin bad++; $display("FAIL false_start_fe got=%0d want=0", fe_cyc.size()); end
        clear_log();
        send_byte(8'h7E, 1'b1, -1, tf);
        idle(20);
        total += 2;
        if (rx_cyc.size() != 1 || rx_cyc[0] != tf + LAT) begin bad++; $display("FAIL after_false_timing got=%0d strobes want=1 at +%0d", rx_cyc.size(), LAT); end
        if (rx_if.po_data !== 8'h7E) begin bad++; $display("FAIL after_false_data got=%h want=7e", rx_if.po_data); end
    endtask

    task automatic test_frame_err();
        int tf;
        idle(40);
        clear_log();
        send_byte(8'h11, 1'b1, -1, tf);
        idle(20);
        total += 1;
        if (rx_cyc.size() != 1 || rx_if.po_data !== 8'h11) begin bad++; $display("FAIL ferr_pre_byte got=%h want=11", rx_if.po_data); end
        clear_log();
        send_byte(8'h3C, 1'b0, -1, tf);
        repeat (100) @(posedge clk);
        #1;
        total += 4;
        if (fe_cyc.size() != 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", fe_cyc.size()); end
        if (fe_cyc.size() < 1 || fe_cyc[0] != tf + LAT) begin bad++; $display("FAIL ferr_latency got=%0d want=%0d", (fe_cyc.size() > 0) ? fe_cyc[0] - tf : -1, LAT); end
        if (rx_cyc.size() != 0) begin bad++; $display("FAIL ferr_rx_down got=%0d want=0", rx_cyc.size()); end
        if (rx_if.po_data !== 8'h11) begin bad++; $display("FAIL ferr_po_hold got=%h want=11", rx_if.po_data); end
        idle(40);
        total += 1;
        if (fe_cyc.size() != 1 || rx_cyc.size() != 0) begin bad++; $display("FAIL break_release got=%0d/%0d strobes want=1/0", fe_cyc.size(), rx_cyc.size()); end
    endtask

    task automatic test_glitch();
        int tf;
        idle(40);
        clear_log();
        send_byte(8'hFF, 1'b1, 4, tf);
        idle(20);
        total += 3;
        if (rx_cyc.size() != 1) begin bad++; $display("FAIL glitch_count got=%0d want=1", rx_cyc.size()); end
        if (rx_if.po_data !== 8'hFF) begin bad++; $display("FAIL glitch_data got=%h want=ff", rx_if.po_data); end
        if (fe_cyc.size() != 0) begin bad++; $display("FAIL glitch_fe got=%0d want=0", fe_cyc.size()); end
    endtask

    task automatic test_reset_midframe();
        int         tf;
        int         t;
        logic [7:0] b;
        b = 8'h81;
        idle(40);
        clear_log();
        drive_cell(1'b0, -1, t);
        for (int i = 0; i < 4; i++) drive_cell(b[i], -1, t);
        @(posedge clk);
        #1 rx_if.line_rx = b[4];
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx_if.line_rx = 1'b1;
        #1;
        total += 3;
        if (rx_if.po_data !== 8'h00) begin bad++; $display("FAIL midreset_po_data got=%h want=00", rx_if.po_data); end
        if (rx_if.rx_down !== 1'b0) begin bad++; $display("FAIL midreset_rx_down got=%b want=0", rx_if.rx_down); end
        if (rx_if.frame_err !== 1'b0) begin bad++; $display("FAIL midreset_frame_err got=%b want=0", rx_if.frame_err); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(200);
        total += 1;
        if (rx_cyc.size() != 0 || fe_cyc.size() != 0) begin bad++; $display("FAIL midreset_discard got=%0d/%0d strobes want=0/0", rx_cyc.size(), fe_cyc.size()); end
        clear_log();
        send_byte(8'h42, 1'b1, -1, tf);
        idle(20);
        total += 2;
        if (rx_cyc.size() != 1) begin bad++; $display("FAIL midreset_next_count got=%0d want=1", rx_cyc.size()); end
        if (rx_if.po_data !== 8'h42) begin bad++; $display("FAIL midreset_next_data got=%h want=42", rx_if.po_data); end
    endtask

    task automatic test_strobe_rules();
        total += 2;
        if (overlap_n != 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", overlap_n); end
        if (long_n != 0) begin bad++; $display("FAIL strobe_width got=%0d want=0", long_n); end
    endtask

    initial begin
        rx_if.line_rx = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_strobe_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ly.md
Name: uart_rx_ly

Overview:
- UART receiver producing the byte stream that the command decoders consume: po_data[7:0] plus a one-cycle rx_down strobe per received byte.
- One instance per serial source: the host link and the voice module each feed their own instance.
- Its outputs connect directly to the transmit-select block's po_data/rx_down and po_data_voice/rx_down_voice inputs.
- Frame format is fixed at 8N1, LSB first, 2-FF synchronised input, 3-sample majority vote at mid-bit.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; derived BAUD_CNT = CLK_FREQ/BAUD (5208 at defaults), H = BAUD_CNT/2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
line_rx  input  1  raw serial input, asynchronous to clk, idle high
po_data  output  8  last correctly framed byte
rx_down  output  1  one-cycle strobe: po_data updated this cycle
frame_err  output  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Reset values: po_data=8'h00, rx_down=0, frame_err=0, state=IDLE, synchroniser flops=1, counters=0.
- Reset takes effect immediately at any point, including mid-frame. The partial byte is discarded.
- Input path: line_rx goes through 2 flops (sync) and then a third flop (prev). A falling edge is prev=1 & sync=0.
- Baud counter:
  - Counts 0..BAUD_CNT-1 and wraps to 0 at the end of each bit period.
  - It is cleared on leaving IDLE and is held at 0 in IDLE.
  - Samples are taken at counter values H-1, H, H+1. The majority of the three is the bit value, available when counter = H+2.
- States (encoded IDLE=0, START=1, DATA=2, STOP=3):
  - IDLE: on a falling edge go to START. The counter is 0 on the next cycle; call that cycle t0.
  - START:
    - At counter=H+2, if the majority is 1 it is a false start: go to IDLE with no strobe.
    - Otherwise, at counter=BAUD_CNT-1 go to DATA with bit index 0.
  - DATA:
    - At counter=H+2, shift the majority into the MSB of an 8-bit shift register (shift right), so the first bit ends in bit 0.
    - At counter=BAUD_CNT-1, increment the bit index. After index 7 go to STOP.
  - STOP: evaluated at counter=H+2.
    - Majority 1: po_data <= shift register and rx_down=1 for that cycle.
    - Majority 0: frame_err=1 for that cycle and po_data is unchanged.
    - In both cases return to IDLE in the same cycle, which gives half a bit of margin for back-to-back frames.
- Latency: the rx_down/frame_err cycle is t0 + 9*BAUD_CNT + H + 2, counted from the IDLE edge detect. The synchroniser adds 2-3 clk after the pin edge.
- rx_down and frame_err are never high in the same cycle. Neither is ever high for more than one cycle.
- Line held low (break): one frame_err strobe, then IDLE. No new frame starts until the line has returned high and falls again, because the edge detect needs prev=1.
- Line activity in the middle of a bit but outside the sample window H-1..H+1 is ignored. A single-cycle disturbance inside the window is out-voted.
- po_data holds its value indefinitely between frames.
- BAUD_CNT must be ≥ 8. Values below that are unsupported and are flagged by a simulation-only check in the block.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding IDLE/START/DATA/STOP;
  - the BAUD_CNT and H derivation as constant functions of CLK_FREQ and BAUD;
  - the frame constants DATA_BITS=8 and STOP_BIT_IDX=9.
  - The uart_tx_* modules use the same package.
- One sub-module, uart_rx_sync: the 2-FF synchroniser plus prev flop and falling-edge detect. It outputs sync and fall.
- The FSM, baud counter, majority vote and shift register stay in uart_rx_ly.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, BAUD=62_500 (BAUD_CNT=16, H=8); the bench drives 16-clk bit cells.
1. Send 0x55 after 40 idle clk -> exactly one rx_down pulse at t0+154; po_data=0x55; frame_err stays 0.
2. Send 0xA3 then 0x0F back-to-back with no idle bits -> two rx_down pulses 160 clk apart; po_data reads 0xA3, then 0x0F.
3. Pull line_rx low for 5 clk, then high -> no rx_down, no frame_err; FSM back in IDLE by counter=10. A following 0x7E is received correctly.
4. After receiving 0x11, send 0x3C with the stop bit driven low -> frame_err pulse at t0+154, rx_down=0, po_data stays 0x11. Hold the line low for 100 clk: no further strobes until it goes high.
5. Send 0xFF with a 1-clk low glitch at counter=H in data bit 3 -> majority out-votes the glitch; po_data=0xFF, rx_down pulses once.
6. Assert rst_n low for 3 clk midway through data bit 4 of 0x81 -> po_data=0x00, rx_down=0, frame_err=0 immediately. A following 0x42 is received correctly with a single rx_down.
